pim_cmd_dispatch: RTL
=====================

Name: pim_cmd_dispatch

Overview:
- Command front-end for the PIM dot-product MAC engine.
- Accepts dot-product descriptors (base, length, tag) over a valid/ready port and buffers them in a small FIFO.
- Issues them one at a time to the MAC through its start/base/length/busy interface.
- Captures the MAC's written result and returns a tagged response over a valid/ready port; a watchdog reports hung or unresponsive MAC jobs.

Parameters:
ADDR_W, 16, address width of base and result address
DATA_W, 32, result data width
LEN_W, 16, element-count width
TAG_W, 4, command tag width
DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 1024, max cycles in WAIT_DONE before error response

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  descriptor accepted when valid&ready
cmd_base  in  ADDR_W  vector-pair base address
cmd_len  in  LEN_W  element count (0 legal)
cmd_tag  in  TAG_W  caller tag, echoed in response
mac_start  out  1  one-cycle start pulse to MAC
mac_base  out  ADDR_W  base for current job
mac_len  out  LEN_W  length for current job
mac_busy  in  1  MAC busy
mac_wr_en  in  1  MAC result write strobe
mac_wr_addr  in  ADDR_W  MAC result address
mac_wr_data  in  DATA_W  MAC result data
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted when valid&ready
rsp_tag  out  TAG_W  tag of completed job
rsp_addr  out  ADDR_W  result address reported by MAC
rsp_data  out  DATA_W  result value
rsp_err  out  1  1 = job timed out / MAC never went busy
idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (rst_n low, async): FIFO emptied, FSM=IDLE, watchdog=0.
  - Outputs: mac_start=0, mac_base=0, mac_len=0, rsp_valid=0, rsp_tag/addr/data=0, rsp_err=0, cmd_ready=1, idle=1.
  - Reset mid-job abandons the job silently; the MAC is reset by its own reset.
- FIFO: DEPTH entries of {base,len,tag}; registered pointers plus a count of width log2(DEPTH)+1.
  - cmd_ready = (count != DEPTH), driven from registers only.
  - Push on cmd_valid&cmd_ready; pop on IDLE->ISSUE.
  - Simultaneous push and pop keeps count unchanged; pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP:
  - IDLE: if count!=0, pop head into mac_base/mac_len/tag register, set mac_start=1 -> ISSUE.
  - ISSUE: mac_start=0 -> WAIT_BUSY. mac_start is high for exactly one cycle.
  - WAIT_BUSY: mac_busy=1 -> WAIT_DONE, watchdog=0. If mac_busy stays 0 for 4 cycles -> RESP with rsp_err=1, rsp_data=0, rsp_addr=0.
  - WAIT_DONE: watchdog increments each cycle.
    - Completion = mac_busy sampled 0. Capture mac_wr_addr/mac_wr_data into rsp_addr/rsp_data; rsp_err = ~mac_wr_en. -> RESP.
    - If watchdog reaches TIMEOUT-1 with mac_busy still 1 -> RESP, rsp_err=1, rsp_data=0.
  - RESP: rsp_valid=1. rsp_tag/addr/data/err are held stable until rsp_ready; on handshake rsp_valid=0 -> IDLE.
- Completion detection uses only the mac_busy fall. mac_wr_en level is sampled but never used as an edge, so a sticky wr_en from the previous job causes no false completion.
- Latency: descriptor handshake at edge t into an empty FIFO, FSM IDLE -> mac_start high between edges t+1 and t+2.
- Back-to-back jobs: next mac_start no earlier than one cycle after the rsp handshake.
- mac_base/mac_len are held constant from ISSUE through RESP.
- Commands are processed strictly in order; only one job is in flight.
- idle = (count==0) & (state==IDLE), registered-state derived.

Test Plan:
- Single job: push base=0x0010,len=3,tag=5; MAC model busy 1 cycle after start, drops after 8 cycles with wr_data=0x0000002A, wr_addr=0x000F -> one mac_start pulse 1 cycle after accept, mac_base=0x0010, mac_len=3; rsp tag=5, data=0x2A, addr=0x000F, err=0.
- FIFO full: hold rsp_ready=0, push 6 descriptors (DEPTH=4) -> 1 dispatched; 4 buffered; cmd_ready=0 on the 6th; then rsp_ready=1 -> responses drain with tags in push order.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp payload stable; no new mac_start until handshake.
- Dead MAC: mac_busy tied 0 -> rsp_err=1, rsp_data=0, 4 cycles after ISSUE; the next command is still dispatched.
- Hung MAC: TIMEOUT=16, mac_busy stuck 1 -> rsp_err=1 after 16 cycles in WAIT_DONE. Also cover len=0 job (busy pulses 2 cycles) -> normal response, err=0.
- Async reset: assert rst_n low mid-WAIT_DONE with 2 entries queued, off the clock edge -> outputs at reset values immediately; after release idle=1, cmd_ready=1, no stale response.

Source files
------------

// File: rtl/pim_cmd_dispatch.sv
// pim_cmd_dispatch: buffers dot-product descriptors and runs them one at a time
// on the PIM MAC, returning a tagged response (or an error on a dead/hung MAC).
module pim_cmd_dispatch #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              mac_start,
    output logic [ADDR_W-1:0] mac_base,
    output logic [LEN_W-1:0]  mac_len,
    input  logic              mac_busy,
    input  logic              mac_wr_en,
    input  logic [ADDR_W-1:0] mac_wr_addr,
    input  logic [DATA_W-1:0] mac_wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT);
    localparam int unsigned BW_W  = 2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    // Four consecutive idle samples in WAIT_BUSY declare the MAC dead
    localparam logic [BW_W-1:0]  BW_LAST  = BW_W'(3);

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        logic [TAG_W-1:0]  tag;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;

    cmd_t              fifo_mem [DEPTH];
    cmd_t              head;
    cmd_t              wr_entry;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              push;
    logic              pop;

    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;
    logic [BW_W-1:0]   bcnt_q;
    logic [BW_W-1:0]   bcnt_d;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  tag_d;

    logic              cmd_ready_d;
    logic              mac_start_d;
    logic [ADDR_W-1:0] mac_base_d;
    logic [LEN_W-1:0]  mac_len_d;
    logic              rsp_valid_d;
    logic [TAG_W-1:0]  rsp_tag_d;
    logic [ADDR_W-1:0] rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic              rsp_err_d;
    logic              idle_d;

    assign push     = cmd_valid & cmd_ready;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign head     = fifo_mem[rd_ptr_q];
    assign wr_entry = '{base: cmd_base, len: cmd_len, tag: cmd_tag};

    // Descriptor storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_entry;
        end
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wd_q      <= '0;
            bcnt_q    <= '0;
            tag_q     <= '0;
            cmd_ready <= 1'b1;
            mac_start <= 1'b0;
            mac_base  <= '0;
            mac_len   <= '0;
            rsp_valid <= 1'b0;
            rsp_tag   <= '0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            idle      <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wd_q      <= wd_d;
            bcnt_q    <= bcnt_d;
            tag_q     <= tag_d;
            cmd_ready <= cmd_ready_d;
            mac_start <= mac_start_d;
            mac_base  <= mac_base_d;
            mac_len   <= mac_len_d;
            rsp_valid <= rsp_valid_d;
            rsp_tag   <= rsp_tag_d;
            rsp_addr  <= rsp_addr_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            idle      <= idle_d;
        end
    end

    // Job sequencing; completion is the busy fall only, never the wr_en level
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (mac_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (bcnt_q == BW_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                if (!mac_busy || (wd_q == WD_LAST)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values for job registers, counters and the registered outputs
    always_comb begin
        mac_base_d = mac_base;
        mac_len_d  = mac_len;
        tag_d      = tag_q;
        rsp_tag_d  = rsp_tag;
        rsp_addr_d = rsp_addr;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;
        wd_d       = wd_q;
        bcnt_d     = bcnt_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    mac_base_d = head.base;
                    mac_len_d  = head.len;
                    tag_d      = head.tag;
                end
            end
            S_ISSUE: begin
                bcnt_d = '0;
            end
            S_WAIT_BUSY: begin
                if (mac_busy) begin
                    wd_d = '0;
                end else if (bcnt_q == BW_LAST) begin
                    rsp_addr_d = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + BW_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!mac_busy) begin
                    rsp_addr_d = mac_wr_addr;
                    rsp_data_d = mac_wr_data;
                    rsp_err_d  = ~mac_wr_en;
                end else if (wd_q == WD_LAST) begin
                    rsp_addr_d = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
            end
        endcase

        if ((state_d == S_RESP) && (state_q != S_RESP)) begin
            rsp_tag_d = tag_q;
        end

        mac_start_d = (state_d == S_ISSUE);
        rsp_valid_d = (state_d == S_RESP);
        cmd_ready_d = (count_d != CNT_FULL);
        idle_d      = (count_d == '0) && (state_d == S_IDLE);
    end

endmodule
